// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Iterative radix-2 multiply/divide unit that owns the HI/LO pair.
//            MULT/MULTU/MADD/MSUB/DIV/DIVU take 33 cycles of Busy.
//            MTHI/MTLO write in a single cycle.
// Config   : MULDIV_DIV_EN - when defined, builds the restoring divider.
//            When undefined, DIV/DIVU act as single-cycle no-ops that still
//            pulse Done.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;       // latched opcode of the op in flight
  logic [4:0]  cnt;        // step counter, 0..31
  logic [63:0] acc;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;       // multiplicand or divisor magnitude
  logic        sign_q;     // negate product / quotient in FIN

  logic        is_move;
  logic        is_div;
  logic        is_signed;
  logic        iter_issue;
  logic        one_cycle_issue;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_res;

  assign is_move   = (op == OP_MTHI) || (op == OP_MTLO);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  assign a_mag     = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign b_mag     = (is_signed && b[31]) ? (32'd0 - b) : b;

`ifdef MULDIV_DIV_EN
  assign iter_issue      = start && !is_move;
  assign one_cycle_issue = start && is_move;
`else
  assign iter_issue      = start && !is_move && !is_div;
  assign one_cycle_issue = start && (is_move || is_div);
`endif

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole 65-bit value right by one.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign prod_res = sign_q ? (64'd0 - acc) : acc;

`ifdef MULDIV_DIV_EN
  logic        sign_r;     // negate remainder in FIN
  logic [32:0] div_trial;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits; the trial can reach 33 bits, so the
  // compare uses a 34-bit difference.
  assign div_trial = {acc[63:32], acc[31]};
  assign div_diff  = {1'b0, div_trial} - {2'b00, opnd};
  assign div_ge    = !div_diff[33];
  assign div_next  = {(div_ge ? div_diff[31:0] : div_trial[31:0]), acc[30:0], div_ge};
  assign quo_res   = sign_q ? (32'd0 - acc[31:0])  : acc[31:0];
  assign rem_res   = sign_r ? (32'd0 - acc[63:32]) : acc[63:32];
`endif

  // State register; Busy is registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic: Start only matters in IDLE, so it is ignored while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iter_issue) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO commit and Done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      op_q   <= 3'd0;
      sign_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      sign_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (iter_issue) begin
            op_q   <= op;
            cnt    <= 5'd0;
            sign_q <= is_signed && (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
            sign_r <= is_signed && a[31];
            if (is_div) begin
              acc  <= {32'd0, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {32'd0, b_mag};
              opnd <= a_mag;
            end
`else
            acc  <= {32'd0, b_mag};
            opnd <= a_mag;
`endif
          end else if (one_cycle_issue) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            done <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
`ifdef MULDIV_DIV_EN
          acc <= op_q[2] ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
        end
        FIN: begin
          done <= 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi, lo} <= prod_res;
            OP_MADD:           {hi, lo} <= {hi, lo} + prod_res;
            OP_MSUB:           {hi, lo} <= {hi, lo} - prod_res;
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU: begin
              // Divide by zero leaves HI/LO untouched.
              if (opnd != 32'd0) begin
                hi <= rem_res;
                lo <= quo_res;
              end
            end
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Purpose  : Self-checking bench for hilo_muldiv_unit (vector table,
//            scoreboard queue, hand-written reset / busy-start sequences).
//            Divider vectors are included when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  hilo_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] eh, input logic [31:0] el, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.exp_hi = eh; v.exp_lo = el; v.lat = l;
    return v;
  endfunction

  // Issue one op (caller sits at a negedge) and check it through completion.
  // Latency k counts negedges after the sampling edge E0; an iterative op's
  // Done is expected on the 34th (cycle after E33), a one-cycle op's on the 1st.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    bit   seen;
    e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("busy_after_e0 op%0d", o), {63'd0, busy}, {63'd0, lat > 1});
      if (k == 2 && lat > 1) check($sformatf("hilo_frozen op%0d", o), {hi, lo}, {m_hi, m_lo});
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check($sformatf("done_latency op%0d", o), 64'(k), 64'(e.lat));
        check($sformatf("busy_at_done op%0d", o), {63'd0, busy}, 64'd0);
        check($sformatf("hilo op%0d a=%h b=%h", o, x, y), {hi, lo}, {e.hi, e.lo});
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout op%0d actual=no_done required=done", o);
      void'(sb.pop_front());
    end
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int ndone;
    int dk;

    // Vector table; entries depend on HI/LO left by the previous entry.
    vecs.push_back(mk(OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 34));
    vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 34));
    vecs.push_back(mk(OP_MTLO,  32'hFFFF_FFFF, 32'd0,        32'h0000_0002, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk(OP_MTHI,  32'h0000_0000, 32'd0,        32'h0000_0000, 32'hFFFF_FFFF, 1));
    vecs.push_back(mk(OP_MADD,  32'd1,         32'd1,        32'h0000_0001, 32'h0000_0000, 34));
    vecs.push_back(mk(OP_MSUB,  32'd1,         32'd1,        32'h0000_0000, 32'hFFFF_FFFF, 34));
    vecs.push_back(mk(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34));
    vecs.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34));
    vecs.push_back(mk(OP_MADD,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFD, 32'hFFFF_FFFB, 34));
`ifdef MULDIV_DIV_EN
    vecs.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34));
    vecs.push_back(mk(OP_DIVU,  32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 34));
    vecs.push_back(mk(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34));
    vecs.push_back(mk(OP_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 34));
    vecs.push_back(mk(OP_MTHI,  32'h11,        32'd0,        32'h0000_0011, 32'h0000_000E, 1));
    vecs.push_back(mk(OP_MTLO,  32'h22,        32'd0,        32'h0000_0011, 32'h0000_0022, 1));
    vecs.push_back(mk(OP_DIV,   32'd5,         32'd0,        32'h0000_0011, 32'h0000_0022, 34));
`else
    vecs.push_back(mk(OP_DIV,   32'd10,        32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFB, 1));
    vecs.push_back(mk(OP_DIVU,  32'd10,        32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFB, 1));
`endif

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {hi, lo, 30'd0, busy, done}, 96'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);

    // Reset in the middle of a MULT: outputs clear at once, no Done follows.
    run_op(OP_MTHI, 32'h55, 32'd0, 32'h55, m_lo, 1);
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_op", {hi, lo, 30'd0, busy, done}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", 64'(ndone), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 34);

    // Start with MTHI while a MULT is busy: ignored, single Done.
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    dk = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 5) begin start = 1'b1; op = OP_MTHI; a = 32'h99; end
      if (k == 6) begin
        start = 1'b0;
        check("mthi_ignored_busy", {32'd0, hi}, {32'd0, m_hi});
      end
      if (done) begin ndone++; dk = k; end
    end
    check("single_done_busy_start", 64'(ndone), 64'd1);
    check("done_latency_busy_start", 64'(dk), 64'd34);
    check("hilo_busy_start", {hi, lo}, {32'd0, 32'd25});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
